sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Upstream feeder of the SHA-256 message scheduler.
- Accepts the raw message as a stream of big-endian 32-bit words with a valid/ready handshake and appends the SHA-256 padding: byte 0x80, zero fill, and the 64-bit big-endian bit length.
- Writes each 512-bit block into the scheduler's 16-word memory one word per cycle.
- Pulses start_new_block once per completed block, then stalls until the compression side acknowledges the block.

Parameters:
- LEN_BITS, 64, width of the internal bit-length counter. Legal range 32..64; zero-extended to 64 bits when emitted.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_data  in  32  message word; first byte in [31:24]
- in_valid  in  1  in_data valid
- in_last  in  1  this beat is the final message beat
- in_nbytes  in  3  valid bytes in the last beat, 0..4; ignored when in_last=0
- in_ready  out  1  padder accepts a beat this cycle
- message_word_out  out  32  word to the scheduler memory
- message_word_addr  out  4  write address 0..15
- write_enable_out  out  1  write strobe
- start_new_block  out  1  one-cycle pulse: a full block has been written
- block_last  out  1  qualifies start_new_block: this is the final padded block
- block_done  in  1  compression core has finished the current block
- msg_done  out  1  one-cycle pulse after the final block is acknowledged
- busy  out  1  high from the first accepted beat until msg_done

Behaviour:
- Reset values: all outputs 0 except in_ready=1. State=LOAD, word_cnt=0, bit_len=0.
- All outputs are registered. A beat accepted at edge N appears as write_enable_out=1 with message_word_addr=word_cnt during cycle N+1. Padder-generated words are emitted at one per cycle.
- Handshake: a beat is accepted when in_valid && in_ready.
  - in_ready=1 only in LOAD with word_cnt<=15.
  - in_data/in_last must stay stable while in_valid=1 && in_ready=0.
- States: LOAD, PAD, LEN_HI, LEN_LO, BLK_WAIT.
- LOAD, non-last beat:
  - Write in_data; bit_len += 32; word_cnt++.
  - After addr 15 is written, go to BLK_WAIT with final=0.
- LOAD, last beat with n = in_nbytes:
  - n=0..3: write the n data bytes, 0x80 in byte position n, zeros below. Examples: n=0 gives 0x80000000; n=3 gives {b0,b1,b2,0x80}.
  - n=4: write the full word, then the next word is 0x80000000 (emitted in PAD).
  - bit_len += 8*n.
  - Let p = address holding 0x80.
  - If p<=13: zero-fill addresses p+1..13, then LEN_HI at 14, LEN_LO at 15.
  - If p is 14 or 15: zero-fill to 15, close the block with final=0 and an extra-block flag set. The next block is zeros at 0..13, then the length at 14..15.
- LEN_HI writes bit_len[63:32]; LEN_LO writes bit_len[31:0], then goes to BLK_WAIT with final=1.
- BLK_WAIT:
  - On entry, start_new_block=1 for exactly one cycle, with block_last=final in that same cycle.
  - In BLK_WAIT, in_ready=0 and write_enable_out=0.
  - On block_done: word_cnt=0.
    - If final=1: pulse msg_done, clear bit_len and busy, go to LOAD.
    - Else if the extra block is pending: go to PAD.
    - Else: go to LOAD.
- block_done outside BLK_WAIT, or in the same cycle as the start_new_block pulse, is ignored; it must arrive at least one cycle after the pulse.
- A new message's first beat is accepted in the cycle after msg_done; no gap cycle is required.
- bit_len wraps modulo 2^LEN_BITS.
- word_cnt is 4 bits; 15->0 wrap occurs only via BLK_WAIT.
- reset_n low mid-operation:
  - Abandons the block at the next edge; no start_new_block or msg_done is emitted.
  - Partially written scheduler memory is left as-is.
- Illegal input: in_nbytes>4 on a last beat is treated as 4.

Test Plan:
- "abc" (in_data=0x61626300, in_last=1, in_nbytes=3):
  - Writes 0x61626380 at addr 0, zeros at 1..14, 0x00000018 at 15.
  - start_new_block pulses with block_last=1.
  - After block_done, msg_done pulses.
- Empty message (in_last=1, in_nbytes=0):
  - addr0=0x80000000, addr1..15=0.
  - One block, block_last=1.
- 55-byte message (13 full beats + last with in_nbytes=3):
  - addr13 = {b52,b53,b54,0x80}, addr14=0, addr15=0x000001B8.
  - Exactly one block.
- 56-byte message (14 full beats, last with in_nbytes=4):
  - Block 1: addr14=0x80000000, addr15=0, block_last=0.
  - Block 2: addr0..14=0, addr15=0x000001C0, block_last=1.
- 64-byte message with block_done held off 40 cycles:
  - in_ready=0 throughout the wait.
  - start_new_block is a single pulse.
  - Second block: 0x80000000 at addr0, length 0x200 at addr15.
- reset_n low during word 7 of block 1, then "abc":
  - Outputs return to reset values.
  - No msg_done for the aborted message.
  - "abc" produces the same result as the first scenario.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams big-endian message words into the scheduler's
// 16-word block memory, appending 0x80, zero fill and the 64-bit bit length.
module sha256_msg_padder #(
  parameter int LEN_BITS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic        in_ready,
  output logic [31:0] message_word_out,
  output logic [3:0]  message_word_addr,
  output logic        write_enable_out,
  output logic        start_new_block,
  output logic        block_last,
  input  logic        block_done,
  output logic        msg_done,
  output logic        busy
);

  typedef enum logic [2:0] {LOAD, PAD, LEN_HI, LEN_LO, BLK_WAIT} state_t;

  state_t              state;
  logic [3:0]          word_cnt;
  logic [LEN_BITS-1:0] bit_len;
  logic                final_blk;  // block being closed carries the length
  logic                extra_blk;  // 0x80 landed at 14/15: length goes in a further block
  logic                need_80;    // last beat was full, 0x80 still owed as the next word
  logic                snb_pend;   // start_new_block due on the first BLK_WAIT cycle

  logic [2:0]  n_eff;
  logic [31:0] last_word;
  logic [63:0] len64;
  logic        accept;

  always_comb begin
    n_eff = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    case (n_eff)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
  end

  assign len64  = 64'(bit_len);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= LOAD;
      word_cnt          <= 4'd0;
      bit_len           <= '0;
      final_blk         <= 1'b0;
      extra_blk         <= 1'b0;
      need_80           <= 1'b0;
      snb_pend          <= 1'b0;
      in_ready          <= 1'b1;
      message_word_out  <= 32'h0;
      message_word_addr <= 4'd0;
      write_enable_out  <= 1'b0;
      start_new_block   <= 1'b0;
      block_last        <= 1'b0;
      msg_done          <= 1'b0;
      busy              <= 1'b0;
    end else begin
      // NOTE: strobes default low here so every later non-blocking assignment in this
      // block overrides them; all state updates use <= so reads see last-cycle values.
      write_enable_out <= 1'b0;
      start_new_block  <= 1'b0;
      block_last       <= 1'b0;
      msg_done         <= 1'b0;

      case (state)
        LOAD: begin
          if (accept) begin
            busy              <= 1'b1;
            write_enable_out  <= 1'b1;
            message_word_addr <= word_cnt;
            word_cnt          <= word_cnt + 4'd1;
            if (!in_last) begin
              message_word_out <= in_data;
              bit_len          <= bit_len + LEN_BITS'(32);
              if (word_cnt == 4'd15) begin
                state     <= BLK_WAIT;
                in_ready  <= 1'b0;
                final_blk <= 1'b0;
                snb_pend  <= 1'b1;
              end
            end else begin
              message_word_out <= last_word;
              bit_len          <= bit_len + LEN_BITS'({n_eff, 3'b000});
              in_ready         <= 1'b0;
              need_80          <= (n_eff == 3'd4);
              extra_blk        <= (n_eff != 3'd4) && (word_cnt >= 4'd14);
              if (word_cnt == 4'd15) begin
                state     <= BLK_WAIT;
                final_blk <= 1'b0;
                snb_pend  <= 1'b1;
              end else if (word_cnt == 4'd13 && n_eff != 3'd4) begin
                state <= LEN_HI;
              end else begin
                state <= PAD;
              end
            end
          end
        end

        PAD: begin
          write_enable_out  <= 1'b1;
          message_word_addr <= word_cnt;
          word_cnt          <= word_cnt + 4'd1;
          message_word_out  <= need_80 ? 32'h8000_0000 : 32'h0;
          need_80           <= 1'b0;
          if (need_80 && word_cnt >= 4'd14) extra_blk <= 1'b1;
          if (word_cnt == 4'd15) begin
            state     <= BLK_WAIT;
            final_blk <= 1'b0;
            snb_pend  <= 1'b1;
          end else if (word_cnt == 4'd13) begin
            state <= LEN_HI;
          end
        end

        LEN_HI: begin
          write_enable_out  <= 1'b1;
          message_word_addr <= word_cnt;
          word_cnt          <= word_cnt + 4'd1;
          message_word_out  <= len64[63:32];
          state             <= LEN_LO;
        end

        LEN_LO: begin
          write_enable_out  <= 1'b1;
          message_word_addr <= word_cnt;
          word_cnt          <= word_cnt + 4'd1;
          message_word_out  <= len64[31:0];
          state             <= BLK_WAIT;
          final_blk         <= 1'b1;
          snb_pend          <= 1'b1;
        end

        BLK_WAIT: begin
          start_new_block <= snb_pend;
          block_last      <= snb_pend && final_blk;
          snb_pend        <= 1'b0;
          // An acknowledge coinciding with (or preceding) the pulse is not for this block.
          if (block_done && !snb_pend && !start_new_block) begin
            word_cnt <= 4'd0;
            if (final_blk) begin
              msg_done  <= 1'b1;
              busy      <= 1'b0;
              bit_len   <= '0;
              final_blk <= 1'b0;
              state     <= LOAD;
              in_ready  <= 1'b1;
            end else if (extra_blk || need_80) begin
              extra_blk <= 1'b0;
              state     <= PAD;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: random byte messages are padded by a
// byte-level reference model and compared block by block with the captured memory.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        in_ready;
  logic [31:0] message_word_out;
  logic [3:0]  message_word_addr;
  logic        write_enable_out;
  logic        start_new_block;
  logic        block_last;
  logic        block_done;
  logic        msg_done;
  logic        busy;

  sha256_msg_padder #(.LEN_BITS(64)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_last           (in_last),
    .in_nbytes         (in_nbytes),
    .in_ready          (in_ready),
    .message_word_out  (message_word_out),
    .message_word_addr (message_word_addr),
    .write_enable_out  (write_enable_out),
    .start_new_block   (start_new_block),
    .block_last        (block_last),
    .block_done        (block_done),
    .msg_done          (msg_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef byte unsigned bq_t[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scheduler memory image and block/event capture
  logic [31:0]  mem [16];
  logic [511:0] snap;
  logic [511:0] blk_q[$];
  logic         last_q[$];
  int           wr_cnt, snb_cnt, done_cnt, ready_hi;

  always @(negedge clk) begin
    if (write_enable_out) begin
      mem[message_word_addr] = message_word_out;
      wr_cnt++;
    end
    if (start_new_block) begin
      for (int i = 0; i < 16; i++) snap[511-32*i -: 32] = mem[i];
      blk_q.push_back(snap);
      last_q.push_back(block_last);
      snb_cnt++;
    end
    if (msg_done) done_cnt++;
  end

  function automatic logic [31:0] word_of(input logic [511:0] b, input int i);
    return b[511-32*i -: 32];
  endfunction

  // Reference: byte-level SHA-256 padding, split into 512-bit blocks
  logic [511:0] exp_q[$];

  task automatic build_expected(input bq_t msg);
    bq_t          p;
    logic [63:0]  bits;
    logic [511:0] v;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) v[511-8*j -: 8] = p[64*b+j];
      exp_q.push_back(v);
    end
  endtask

  task automatic drive_msg(input bq_t msg, input int max_gap, input int stop_after, input bit rnd);
    int nbeats, nlast, t;
    logic [31:0] w;
    bit last;
    nbeats = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    nlast  = msg.size() - 4 * (nbeats - 1);
    for (int k = 0; k < nbeats; k++) begin
      if (stop_after >= 0 && k == stop_after) break;
      if (max_gap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      end
      w = rnd ? $urandom : 32'h0;
      for (int j = 0; j < 4; j++)
        if (4*k + j < msg.size()) w[31-8*j -: 8] = msg[4*k+j];
      last      = (k == nbeats - 1);
      in_data   = w;
      in_last   = last;
      in_nbytes = last ? 3'(nlast) : (rnd ? 3'($urandom_range(7, 0)) : 3'd0);
      if (last && nlast == 4 && rnd) in_nbytes = 3'($urandom_range(7, 4));
      in_valid  = 1'b1;
      t = 0;
      while (!in_ready && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) begin
        check("in_ready_timeout", 512'(t), 512'(0));
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic respond(input int nblk, input int hold, input bit glitch);
    int t, d;
    for (int b = 0; b < nblk; b++) begin
      t = 0;
      while (!start_new_block && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) begin
        check("start_timeout", 512'(t), 512'(0));
        return;
      end
      check("busy_at_block", 512'(busy), 512'(1));
      if (glitch) begin
        block_done = 1'b1;
        @(negedge clk);
        block_done = 1'b0;
      end
      d = (hold > 0) ? hold : $urandom_range(6, 1);
      repeat (d) begin
        @(negedge clk);
        if (in_ready) ready_hi++;
      end
      if (b == nblk - 1) check("no_early_msg_done", 512'(done_cnt), 512'(0));
      block_done = 1'b1;
      @(negedge clk);
      block_done = 1'b0;
    end
  endtask

  task automatic run_msg(input string name, input bq_t msg, input int max_gap,
                         input int hold, input bit glitch, input bit rnd);
    int nblk;
    build_expected(msg);
    nblk = exp_q.size();
    blk_q.delete();
    last_q.delete();
    wr_cnt = 0; snb_cnt = 0; done_cnt = 0; ready_hi = 0;
    fork
      drive_msg(msg, max_gap, -1, rnd);
      respond(nblk, hold, glitch);
    join
    repeat (3) @(negedge clk);
    check({name, "_blocks"}, 512'(snb_cnt), 512'(nblk));
    for (int i = 0; i < nblk && i < blk_q.size(); i++) begin
      check($sformatf("%s_blk%0d", name, i), blk_q[i], exp_q[i]);
      check($sformatf("%s_last%0d", name, i), 512'(last_q[i]), 512'(i == nblk - 1));
    end
    check({name, "_writes"}, 512'(wr_cnt), 512'(16 * nblk));
    check({name, "_ready_in_wait"}, 512'(ready_hi), 512'(0));
    check({name, "_msg_done"}, 512'(done_cnt), 512'(1));
    check({name, "_busy_after"}, 512'(busy), 512'(0));
    check({name, "_ready_after"}, 512'(in_ready), 512'(1));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 512'(in_ready), 512'(1));
    check({tag, "_we"}, 512'(write_enable_out), 512'(0));
    check({tag, "_word"}, 512'(message_word_out), 512'(0));
    check({tag, "_addr"}, 512'(message_word_addr), 512'(0));
    check({tag, "_snb"}, 512'(start_new_block), 512'(0));
    check({tag, "_blast"}, 512'(block_last), 512'(0));
    check({tag, "_msg_done"}, 512'(msg_done), 512'(0));
    check({tag, "_busy"}, 512'(busy), 512'(0));
  endtask

  task automatic abc_checks(input string tag);
    check({tag, "_w0"}, 512'(word_of(blk_q[0], 0)), 512'(32'h6162_6380));
    check({tag, "_w15"}, 512'(word_of(blk_q[0], 15)), 512'(32'h0000_0018));
  endtask

  initial begin
    bq_t msg;
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_nbytes = 3'd0;
    in_data = 32'h0; block_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    @(negedge clk);

    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", msg, 0, 2, 1'b0, 1'b0);
    abc_checks("abc");

    msg.delete();
    run_msg("empty", msg, 0, 1, 1'b0, 1'b0);
    check("empty_w0", 512'(word_of(blk_q[0], 0)), 512'(32'h8000_0000));

    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'($urandom));
    run_msg("len55", msg, 1, 0, 1'b0, 1'b1);
    check("len55_w13", 512'(word_of(blk_q[0], 13)), 512'({msg[52], msg[53], msg[54], 8'h80}));
    check("len55_w15", 512'(word_of(blk_q[0], 15)), 512'(32'h0000_01B8));

    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    run_msg("len56", msg, 0, 0, 1'b0, 1'b0);
    check("len56_b0w14", 512'(word_of(blk_q[0], 14)), 512'(32'h8000_0000));
    check("len56_b1w15", 512'(word_of(blk_q[1], 15)), 512'(32'h0000_01C0));

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    run_msg("len64", msg, 0, 40, 1'b0, 1'b0);
    check("len64_b1w0", 512'(word_of(blk_q[1], 0)), 512'(32'h8000_0000));
    check("len64_b1w15", 512'(word_of(blk_q[1], 15)), 512'(32'h0000_0200));

    // Abort a message mid-block with reset, then confirm a clean restart
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    snb_cnt = 0; done_cnt = 0;
    drive_msg(msg, 0, 7, 1'b0);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("abort");
    in_valid = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_snb", 512'(snb_cnt), 512'(0));
    check("abort_no_done", 512'(done_cnt), 512'(0));
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("abc2", msg, 0, 2, 1'b0, 1'b0);
    abc_checks("abc2");

    for (int r = 0; r < 30; r++) begin
      msg.delete();
      repeat ($urandom_range(200, 0)) msg.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d_len%0d", r, msg.size()), msg, 2, 0, 1'($urandom_range(1, 0)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
